// File: rtl/adc_measure.sv
// Gated measurement of the narrowed ADC stream: per-window max/min/peak-to-peak
// and a hysteretic rising-crossing count used as a frequency estimate.
module adc_measure #(
    parameter int GATE_CYCLES = 1000000,
    parameter int HYST        = 4,
    parameter int CNT_W       = 32
) (
    input  logic             adc_clk,
    input  logic             rst,
    input  logic             run,
    input  logic             sample_en,
    input  logic [7:0]       adc_data_narrow,
    output logic             meas_valid,
    output logic [7:0]       vmax,
    output logic [7:0]       vmin,
    output logic [7:0]       vpp,
    output logic [CNT_W-1:0] freq_cnt,
    output logic [7:0]       level
);

    localparam int GW = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [7:0]    HYST8     = 8'(HYST);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WARMUP  = 2'd1;
    localparam logic [1:0] MEASURE = 2'd2;

    logic [1:0]       state;
    logic [GW-1:0]    gate_cnt;
    logic             armed;
    logic [7:0]       run_max;
    logic [7:0]       run_min;
    logic [CNT_W-1:0] run_cnt;

    logic [7:0]       lo;
    logic [7:0]       hi;
    logic [8:0]       hi_sum;
    logic [7:0]       max_next;
    logic [7:0]       min_next;
    logic             arm_set;
    logic             hit;
    logic             armed_next;
    logic [CNT_W-1:0] cnt_next;
    logic             seen;
    logic [8:0]       mid_sum;
    logic [7:0]       vpp_next;
    logic             last;

    // Thresholds saturate at the rails rather than wrapping.
    always_comb begin
        lo     = (level >= HYST8) ? level - HYST8 : 8'h00;
        hi_sum = {1'b0, level} + {1'b0, HYST8};
        hi     = hi_sum[8] ? 8'hFF : hi_sum[7:0];
    end

    // Next accumulator values including this cycle's sample.
    always_comb begin
        max_next   = (sample_en && adc_data_narrow > run_max) ? adc_data_narrow : run_max;
        min_next   = (sample_en && adc_data_narrow < run_min) ? adc_data_narrow : run_min;
        arm_set    = sample_en && (adc_data_narrow < lo);
        hit        = sample_en && armed && (adc_data_narrow >= hi);
        armed_next = hit ? 1'b0 : (arm_set ? 1'b1 : armed);
        cnt_next   = (hit && run_cnt != {CNT_W{1'b1}}) ? run_cnt + CNT_W'(1) : run_cnt;
        // Any sample leaves max >= min; an empty window keeps max=00, min=FF.
        seen       = max_next >= min_next;
        mid_sum    = {1'b0, max_next} + {1'b0, min_next};
        vpp_next   = seen ? max_next - min_next : 8'h00;
        last       = (gate_cnt == GATE_LAST);
    end

    always_ff @(posedge adc_clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            gate_cnt   <= '0;
            armed      <= 1'b0;
            run_max    <= 8'h00;
            run_min    <= 8'hFF;
            run_cnt    <= '0;
            meas_valid <= 1'b0;
            vmax       <= 8'h00;
            vmin       <= 8'h00;
            vpp        <= 8'h00;
            freq_cnt   <= '0;
            level      <= 8'h80;
        end else begin
            meas_valid <= 1'b0;
            case (state)
                WARMUP, MEASURE: begin
                    if (!run) begin
                        state    <= IDLE;
                        gate_cnt <= '0;
                        armed    <= 1'b0;
                        run_max  <= 8'h00;
                        run_min  <= 8'hFF;
                        run_cnt  <= '0;
                    end else if (last) begin
                        gate_cnt <= '0;
                        run_max  <= 8'h00;
                        run_min  <= 8'hFF;
                        run_cnt  <= '0;
                        armed    <= armed_next;
                        if (seen) begin
                            level <= mid_sum[8:1];
                        end
                        if (state == MEASURE) begin
                            vmax       <= max_next;
                            vmin       <= min_next;
                            vpp        <= vpp_next;
                            freq_cnt   <= cnt_next;
                            meas_valid <= 1'b1;
                        end
                        state <= MEASURE;
                    end else begin
                        gate_cnt <= gate_cnt + GW'(1);
                        run_max  <= max_next;
                        run_min  <= min_next;
                        run_cnt  <= cnt_next;
                        armed    <= armed_next;
                    end
                end
                default: begin
                    gate_cnt <= '0;
                    armed    <= 1'b0;
                    run_max  <= 8'h00;
                    run_min  <= 8'hFF;
                    run_cnt  <= '0;
                    state    <= run ? WARMUP : IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_measure.sv
// Directed bench for adc_measure: expected window results are queued with their
// due cycle when a run starts and compared when the pulse is due.
module tb_adc_measure;

    localparam int GATE = 100;

    logic        adc_clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic        sample_en = 1'b0;
    logic [7:0]  adc_data_narrow = 8'h00;

    logic        meas_valid, meas_valid0;
    logic [7:0]  vmax, vmin, vpp, level;
    logic [7:0]  vmax0, vmin0, vpp0, level0;
    logic [31:0] freq_cnt, freq_cnt0;

    adc_measure #(.GATE_CYCLES(GATE), .HYST(4), .CNT_W(32)) dut (
        .adc_clk(adc_clk), .rst(rst), .run(run), .sample_en(sample_en),
        .adc_data_narrow(adc_data_narrow), .meas_valid(meas_valid),
        .vmax(vmax), .vmin(vmin), .vpp(vpp), .freq_cnt(freq_cnt), .level(level)
    );

    adc_measure #(.GATE_CYCLES(GATE), .HYST(0), .CNT_W(32)) dut0 (
        .adc_clk(adc_clk), .rst(rst), .run(run), .sample_en(sample_en),
        .adc_data_narrow(adc_data_narrow), .meas_valid(meas_valid0),
        .vmax(vmax0), .vmin(vmin0), .vpp(vpp0), .freq_cnt(freq_cnt0), .level(level0)
    );

    always #5 adc_clk = ~adc_clk;

    typedef struct {
        int         at;
        logic [7:0] vmax;
        logic [7:0] vmin;
        logic [7:0] vpp;
        int         freq;
        logic [7:0] level;
        int         freq0;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   start = 0;
    int   pcnt = 0;
    int   run_stop = 0;
    int   en_stop = 0;
    int   mode = 0;
    logic [7:0] cval = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input int at, input logic [7:0] mx, input logic [7:0] mn,
                        input logic [7:0] pp, input int fq, input logic [7:0] lv, input int fq0);
        exp_t e;
        e.at = at; e.vmax = mx; e.vmin = mn; e.vpp = pp;
        e.freq = fq; e.level = lv; e.freq0 = fq0;
        sb.push_back(e);
    endtask

    task automatic drive();
        run       = (pcnt < run_stop);
        sample_en = (pcnt < en_stop);
        case (mode)
            1:       adc_data_narrow = ((pcnt % 10) < 5) ? 8'h20 : 8'hE0;
            2:       adc_data_narrow = ((pcnt % 2) == 1) ? 8'h81 : 8'h7F;
            default: adc_data_narrow = cval;
        endcase
        pcnt++;
    endtask

    task automatic check_cycle();
        logic due;
        exp_t e;
        due = (sb.size() > 0) && (sb[0].at == cyc);
        chk("meas_valid", {31'b0, meas_valid}, {31'b0, due});
        chk("meas_valid_h0", {31'b0, meas_valid0}, {31'b0, due});
        if (due) begin
            e = sb.pop_front();
            $display("window @%0d: vmax=%0h vmin=%0h vpp=%0h freq=%0d level=%0h freq_h0=%0d",
                     cyc, vmax, vmin, vpp, freq_cnt, level, freq_cnt0);
            chk("vmax", {24'b0, vmax}, {24'b0, e.vmax});
            chk("vmin", {24'b0, vmin}, {24'b0, e.vmin});
            chk("vpp", {24'b0, vpp}, {24'b0, e.vpp});
            chk("freq_cnt", freq_cnt, e.freq);
            chk("level", {24'b0, level}, {24'b0, e.level});
            chk("vmax_h0", {24'b0, vmax0}, {24'b0, e.vmax});
            chk("level_h0", {24'b0, level0}, {24'b0, e.level});
            if (e.freq0 >= 0) chk("freq_cnt_h0", freq_cnt0, e.freq0);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            drive();
            @(posedge adc_clk);
            cyc++;
            @(negedge adc_clk);
            check_cycle();
        end
    endtask

    task automatic start_run(input int m, input logic [7:0] c, input int en_lim, input int stop);
        mode     = m;
        cval     = c;
        en_stop  = en_lim;
        run_stop = stop;
        pcnt     = 0;
        start    = cyc + 1;
    endtask

    task automatic reset_checks();
        chk("rst_meas_valid", {31'b0, meas_valid}, 32'd0);
        chk("rst_vmax", {24'b0, vmax}, 32'h00);
        chk("rst_vmin", {24'b0, vmin}, 32'h00);
        chk("rst_vpp", {24'b0, vpp}, 32'h00);
        chk("rst_freq_cnt", freq_cnt, 32'd0);
        chk("rst_level", {24'b0, level}, 32'h80);
        chk("rst_freq_cnt_h0", freq_cnt0, 32'd0);
    endtask

    // Reset is raised between clock edges and checked before the next edge.
    task automatic do_reset();
        chk("pending_windows", sb.size(), 32'd0);
        sb.delete();
        @(negedge adc_clk);
        #1 rst = 1'b1;
        #1 reset_checks();
        $display("async reset @%0d: vmax=%0h freq=%0d level=%0h", cyc, vmax, freq_cnt, level);
        run_stop = 0;
        run = 1'b0;
        @(posedge adc_clk);
        @(negedge adc_clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst = 1'b1;
        #2 reset_checks();
        @(negedge adc_clk);
        @(negedge adc_clk);
        rst = 1'b0;

        // Constant 40: no pulse after warmup, first report 200 cycles after leaving idle.
        start_run(0, 8'h40, 1 << 30, 1 << 30);
        push(start + 200, 8'h40, 8'h40, 8'h00, 0, 8'h40, 1);
        push(start + 300, 8'h40, 8'h40, 8'h00, 0, 8'h40, 0);
        cycles(310);
        do_reset();

        // Square 20/E0, period 10: ten crossings per window.
        start_run(1, 8'h00, 1 << 30, 1 << 30);
        push(start + 200, 8'hE0, 8'h20, 8'hC0, 10, 8'h80, 10);
        push(start + 300, 8'hE0, 8'h20, 8'hC0, 10, 8'h80, 10);
        push(start + 400, 8'hE0, 8'h20, 8'hC0, 10, 8'h80, 10);
        cycles(410);
        do_reset();

        // 7F/81 alternating around level 80: hysteresis suppresses, HYST=0 counts 50.
        start_run(2, 8'h00, 1 << 30, 1 << 30);
        push(start + 200, 8'h81, 8'h7F, 8'h02, 0, 8'h80, 50);
        push(start + 300, 8'h81, 8'h7F, 8'h02, 0, 8'h80, 50);
        cycles(310);
        do_reset();

        // Second measure window with no samples at all.
        start_run(0, 8'h40, 201, 1 << 30);
        push(start + 200, 8'h40, 8'h40, 8'h00, 0, 8'h40, 1);
        push(start + 300, 8'h00, 8'hFF, 8'h00, 0, 8'h40, 0);
        cycles(310);
        do_reset();

        // run dropped at gate_cnt=50: window discarded, outputs hold, warmup repeats.
        start_run(0, 8'h40, 1 << 30, 251);
        push(start + 200, 8'h40, 8'h40, 8'h00, 0, 8'h40, 1);
        cycles(300);
        chk("hold_vmax", {24'b0, vmax}, 32'h40);
        chk("hold_vmin", {24'b0, vmin}, 32'h40);
        chk("hold_level", {24'b0, level}, 32'h40);
        start_run(0, 8'h40, 1 << 30, 1 << 30);
        push(start + 200, 8'h40, 8'h40, 8'h00, 0, 8'h40, 0);
        cycles(210);
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
